// File: rtl/wb_exc_ctrl.sv
// Exception/ERTN sequencer at WB: prioritises exception flags, commits to the CSR file,
// holds the pipeline flush, then redirects fetch to the exception entry or the return address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an exception or ERTN on a valid WB instruction
// S_COMMIT| one-cycle CSR commit (exception) or PLV/IE restore (ERTN)
// S_FLUSH | pipeline held flushed while the flush counter runs down
// S_REDIR | redirect offered to fetch until accepted
module wb_exc_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ws_valid,
  input  logic [5:0]       exc_flags,
  input  logic             inst_ertn,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_vaddr,
  input  logic [31:0]      csr_eentry,
  input  logic [31:0]      csr_era,
  input  logic             redirect_ready,
  output logic             wb_cancel,
  output logic             csr_ex_we,
  output logic [5:0]       csr_ecode,
  output logic [8:0]       csr_esubcode,
  output logic [31:0]      csr_ex_pc,
  output logic             csr_badv_we,
  output logic [31:0]      csr_badv,
  output logic             ertn_flush,
  output logic             pipe_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIR} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              kind_exc_q;
  logic [5:0]        ecode_q;
  logic [31:0]       pc_q;
  logic [31:0]       badv_q;
  logic              badv_we_q;
  logic [CNT_W-1:0]  count_q;

  logic              any_exc;
  logic              trigger;
  logic [5:0]        ecode_dec;
  logic              badv_we_dec;
  logic [31:0]       badv_dec;

  assign any_exc = |exc_flags;
  assign trigger = (state_q == S_IDLE) && ws_valid && (any_exc || inst_ertn);

  // Flag order {int,adef,ine,sys,brk,ale}, highest priority first.
  always_comb begin
    ecode_dec   = 6'h00;
    badv_we_dec = 1'b0;
    badv_dec    = 32'h0;
    if (exc_flags[5]) begin
      ecode_dec = 6'h00;
    end else if (exc_flags[4]) begin
      ecode_dec   = 6'h08;
      badv_we_dec = 1'b1;
      badv_dec    = wb_pc;
    end else if (exc_flags[3]) begin
      ecode_dec = 6'h0D;
    end else if (exc_flags[2]) begin
      ecode_dec = 6'h0B;
    end else if (exc_flags[1]) begin
      ecode_dec = 6'h0C;
    end else if (exc_flags[0]) begin
      ecode_dec   = 6'h09;
      badv_we_dec = 1'b1;
      badv_dec    = wb_vaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'h0;
      kind_exc_q <= 1'b0;
      ecode_q    <= 6'h00;
      pc_q       <= 32'h0;
      badv_q     <= 32'h0;
      badv_we_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (trigger) begin
        kind_exc_q <= any_exc;
        ecode_q    <= ecode_dec;
        pc_q       <= wb_pc;
        badv_q     <= badv_dec;
        badv_we_q  <= badv_we_dec;
      end
      if (state_q == S_COMMIT && kind_exc_q && count_q != '1)
        count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    csr_ex_we      = 1'b0;
    csr_badv_we    = 1'b0;
    ertn_flush     = 1'b0;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        csr_ex_we   = kind_exc_q;
        csr_badv_we = kind_exc_q && badv_we_q;
        ertn_flush  = !kind_exc_q;
        pipe_flush  = 1'b1;
        cnt_d       = FLUSH_LOAD;
        state_d     = (FLUSH_LOAD == 4'h0) ? S_REDIR : S_FLUSH;
      end
      S_FLUSH: begin
        pipe_flush = 1'b1;
        cnt_d      = (cnt_q == 4'h0) ? 4'h0 : cnt_q - 4'h1;
        if (cnt_q <= 4'h1) state_d = S_REDIR;
      end
      S_REDIR: begin
        pipe_flush     = 1'b1;
        redirect_valid = 1'b1;
        // CSR commit has already landed, so the live CSR values are the targets.
        redirect_pc    = kind_exc_q ? csr_eentry : csr_era;
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_cancel    = (state_q == S_IDLE) && ws_valid && any_exc;
  assign csr_ecode    = ecode_q;
  assign csr_esubcode = 9'h0;
  assign csr_ex_pc    = pc_q;
  assign csr_badv     = badv_q;
  assign busy         = (state_q != S_IDLE);
  assign exc_count    = count_q;

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Directed bench for wb_exc_ctrl: hand-computed vectors checked with immediate assertions.
module tb_wb_exc_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             ws_valid;
  logic [5:0]       exc_flags;
  logic             inst_ertn;
  logic [31:0]      wb_pc, wb_vaddr, csr_eentry, csr_era;
  logic             redirect_ready;
  logic             wb_cancel, csr_ex_we, csr_badv_we, ertn_flush, pipe_flush;
  logic             redirect_valid, busy;
  logic [5:0]       csr_ecode;
  logic [8:0]       csr_esubcode;
  logic [31:0]      csr_ex_pc, csr_badv, redirect_pc;
  logic [CNT_W-1:0] exc_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  wb_exc_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .exc_flags(exc_flags),
    .inst_ertn(inst_ertn), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .redirect_ready(redirect_ready),
    .wb_cancel(wb_cancel), .csr_ex_we(csr_ex_we), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .csr_ex_pc(csr_ex_pc), .csr_badv_we(csr_badv_we),
    .csr_badv(csr_badv), .ertn_flush(ertn_flush), .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_we"}, 32'(csr_ex_we), 0);
    chk({tag, "_ecode"}, 32'(csr_ecode), 0);
    chk({tag, "_ex_pc"}, csr_ex_pc, 0);
    chk({tag, "_badv_we"}, 32'(csr_badv_we), 0);
    chk({tag, "_badv"}, csr_badv, 0);
    chk({tag, "_ertn_flush"}, 32'(ertn_flush), 0);
    chk({tag, "_pipe_flush"}, 32'(pipe_flush), 0);
    chk({tag, "_redir_valid"}, 32'(redirect_valid), 0);
    chk({tag, "_redir_pc"}, redirect_pc, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, 32'(exc_count), 0);
  endtask

  // One full sequence with redirect_ready high; a second request is offered while busy.
  task automatic seq(input string tag, input logic [5:0] f, input logic e,
                     input logic [31:0] pc, input logic [31:0] va,
                     input logic [5:0] ec, input logic bwe, input logic [31:0] bv);
    logic exc;
    exc = |f;
    ws_valid = 1'b1; exc_flags = f; inst_ertn = e; wb_pc = pc; wb_vaddr = va;
    redirect_ready = 1'b1;
    #1;
    chk({tag, "_cancel"}, 32'(wb_cancel), 32'(exc));
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    tick();
    exc_flags = 6'b000100; inst_ertn = 1'b0; wb_pc = 32'hdead_0000;
    #1;
    chk({tag, "_busy_cancel"}, 32'(wb_cancel), 0);
    chk({tag, "_ex_we"}, 32'(csr_ex_we), 32'(exc));
    chk({tag, "_ertn_flush"}, 32'(ertn_flush), 32'(!exc));
    if (exc) chk({tag, "_ecode"}, 32'(csr_ecode), 32'(ec));
    chk({tag, "_ex_pc"}, csr_ex_pc, pc);
    chk({tag, "_badv_we"}, 32'(csr_badv_we), 32'(bwe));
    if (bwe) chk({tag, "_badv"}, csr_badv, bv);
    chk({tag, "_commit_flush"}, 32'(pipe_flush), 1);
    if (exc && exp_count < CMAX) exp_count++;
    tick();
    ws_valid = 1'b0;
    chk({tag, "_flush_ex_we"}, 32'(csr_ex_we), 0);
    chk({tag, "_flush_ertn"}, 32'(ertn_flush), 0);
    chk({tag, "_flush"}, 32'(pipe_flush), 1);
    chk({tag, "_flush_rv"}, 32'(redirect_valid), 0);
    chk({tag, "_count"}, 32'(exc_count), 32'(exp_count));
    tick();
    chk({tag, "_rv"}, 32'(redirect_valid), 1);
    chk({tag, "_rpc"}, redirect_pc, exc ? csr_eentry : csr_era);
    chk({tag, "_redir_flush"}, 32'(pipe_flush), 1);
    chk({tag, "_pc_stable"}, csr_ex_pc, pc);
    tick();
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_rv"}, 32'(redirect_valid), 0);
    chk({tag, "_done_flush"}, 32'(pipe_flush), 0);
  endtask

  initial begin
    reset = 1'b1; ws_valid = 1'b0; exc_flags = 6'h0; inst_ertn = 1'b0;
    wb_pc = 32'h0; wb_vaddr = 32'h0; redirect_ready = 1'b1;
    csr_eentry = 32'h1c00_8000; csr_era = 32'h1c00_0024;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_cancel", 32'(wb_cancel), 0);
    reset = 1'b0;
    tick();

    seq("sys",     6'b000100, 1'b0, 32'h1c00_0010, 32'h0, 6'h0B, 1'b0, 32'h0);
    seq("int_ale", 6'b100001, 1'b0, 32'h1c00_0020, 32'h3, 6'h00, 1'b0, 32'h0);
    seq("ale",     6'b000001, 1'b0, 32'h1c00_0030, 32'h3, 6'h09, 1'b1, 32'h3);
    seq("adef",    6'b010000, 1'b0, 32'h1c00_0041, 32'h3, 6'h08, 1'b1, 32'h1c00_0041);
    seq("ine",     6'b001000, 1'b0, 32'h1c00_0050, 32'h0, 6'h0D, 1'b0, 32'h0);
    seq("brk",     6'b000010, 1'b0, 32'h1c00_0060, 32'h0, 6'h0C, 1'b0, 32'h0);
    seq("ine_brk", 6'b001010, 1'b0, 32'h1c00_0070, 32'h0, 6'h0D, 1'b0, 32'h0);
    seq("ertn",    6'b000000, 1'b1, 32'h1c00_0080, 32'h0, 6'h00, 1'b0, 32'h0);
    seq("sys_ertn",6'b000100, 1'b1, 32'h1c00_0090, 32'h0, 6'h0B, 1'b0, 32'h0);

    // Redirect back-pressure for five cycles.
    redirect_ready = 1'b0;
    ws_valid = 1'b1; exc_flags = 6'b000100; inst_ertn = 1'b0; wb_pc = 32'h1c00_00a0;
    tick();
    ws_valid = 1'b0;
    if (exp_count < CMAX) exp_count++;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv", 32'(redirect_valid), 1);
      chk("hold_flush", 32'(pipe_flush), 1);
      chk("hold_rpc", redirect_pc, 32'h1c00_8000);
      chk("hold_pc", csr_ex_pc, 32'h1c00_00a0);
      tick();
    end
    redirect_ready = 1'b1;
    #1;
    chk("accept_rv", 32'(redirect_valid), 1);
    tick();
    chk("accept_idle", 32'(busy), 0);
    chk("accept_rv_drop", 32'(redirect_valid), 0);
    chk("count_pre_reset", 32'(exc_count), 32'(exp_count));

    // Reset in the middle of FLUSH.
    ws_valid = 1'b1; exc_flags = 6'b000100; wb_pc = 32'h1c00_00b0;
    tick();
    ws_valid = 1'b0;
    tick();
    chk("mid_in_flush", 32'(pipe_flush), 1);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    exp_count = 0;
    tick();
    seq("post_reset", 6'b000100, 1'b0, 32'h1c00_0010, 32'h0, 6'h0B, 1'b0, 32'h0);

    // 2^CNT_W+3 exceptions in total since reset: counter must stick at all-ones.
    for (int i = 0; i < 18; i++)
      seq("sat", 6'b000100, 1'b0, 32'h1c00_0100, 32'h0, 6'h0B, 1'b0, 32'h0);
    chk("sat_final", 32'(exc_count), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
